// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator: I/S/B/U/J/zimm extraction, sign-extended to XLEN, tag carried alongside.
// Latency: STAGES register stages; accepted at edge N, valid at the output after edge N+STAGES-1.
// Backpressure: valid/ready per stage with ready chained back from out_ready; full throughput, no bubbles.
module imm_gen_pipe #(
    parameter int XLEN   = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instruction,
    input  logic [2:0]        imm_sel,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   immediate,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_err,
    output logic [15:0]       err_count
);

    // Reject unsupported configurations at elaboration.
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end
    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
        $error("imm_gen_pipe: STAGES must be in 1..4");
    end

    localparam logic [2:0] SEL_I    = 3'b000;
    localparam logic [2:0] SEL_S    = 3'b001;
    localparam logic [2:0] SEL_B    = 3'b010;
    localparam logic [2:0] SEL_U    = 3'b011;
    localparam logic [2:0] SEL_J    = 3'b100;
    localparam logic [2:0] SEL_ZIMM = 3'b101;

    // Opcode bits never contribute to any immediate format.
    logic unused_opcode;
    assign unused_opcode = ^instruction[6:0];

    logic [XLEN-1:0] ext_imm;
    logic            ext_err;

    // Combinational extraction of the selected immediate format.
    always_comb begin
        ext_imm = '0;
        ext_err = 1'b0;
        case (imm_sel)
            SEL_I:    ext_imm = {{(XLEN-12){instruction[31]}}, instruction[31:20]};
            SEL_S:    ext_imm = {{(XLEN-12){instruction[31]}}, instruction[31:25], instruction[11:7]};
            SEL_B:    ext_imm = {{(XLEN-12){instruction[31]}}, instruction[7], instruction[30:25],
                                 instruction[11:8], 1'b0};
            // The top bit of the 32-bit U value is inst[31], so it doubles as the extension bit.
            SEL_U:    ext_imm = {{(XLEN-31){instruction[31]}}, instruction[30:12], 12'b0};
            SEL_J:    ext_imm = {{(XLEN-20){instruction[31]}}, instruction[19:12], instruction[20],
                                 instruction[30:21], 1'b0};
            SEL_ZIMM: ext_imm = {{(XLEN-5){1'b0}}, instruction[19:15]};
            default:  ext_err = 1'b1;
        endcase
    end

    logic [STAGES-1:0]             vld_q;
    logic [STAGES-1:0][XLEN-1:0]   imm_q;
    logic [STAGES-1:0][TAG_W-1:0]  tag_q;
    logic [STAGES-1:0]             err_q;
    logic [STAGES-1:0]             stage_rdy;

    // A stage can load when it or any stage downstream of it has a hole, or the sink is draining.
    always_comb begin
        stage_rdy = '0;
        for (int i = 0; i < STAGES; i++) begin
            stage_rdy[i] = out_ready;
            for (int j = i; j < STAGES; j++) begin
                if (!vld_q[j]) begin
                    stage_rdy[i] = 1'b1;
                end
            end
        end
    end

    assign in_ready = stage_rdy[0];

    // Stage registers: advance whenever the slot frees; payload only loads with a valid source.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            imm_q <= '0;
            tag_q <= '0;
            err_q <= '0;
        end else begin
            if (stage_rdy[0]) begin
                vld_q[0] <= in_valid;
                if (in_valid) begin
                    imm_q[0] <= ext_imm;
                    tag_q[0] <= in_tag;
                    err_q[0] <= ext_err;
                end
            end
            for (int i = 1; i < STAGES; i++) begin
                if (stage_rdy[i]) begin
                    vld_q[i] <= vld_q[i-1];
                    if (vld_q[i-1]) begin
                        imm_q[i] <= imm_q[i-1];
                        tag_q[i] <= tag_q[i-1];
                        err_q[i] <= err_q[i-1];
                    end
                end
            end
        end
    end

    logic [15:0] err_cnt_q;
    logic [15:0] err_cnt_d;

    // Count illegal selectors only on an actual input transfer, holding at all-ones.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (in_valid && in_ready && ext_err && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    // Error counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign out_valid = vld_q[STAGES-1];
    assign immediate = imm_q[STAGES-1];
    assign out_tag   = tag_q[STAGES-1];
    assign out_err   = err_q[STAGES-1];
    assign err_count = err_cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: a 32-bit and a 64-bit instance share one stimulus stream;
// a queue model of in-flight items checks both every cycle, directed literals pin the model.
module tb_imm_gen_pipe;

    localparam int S  = 2;
    localparam int TW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [31:0]   instruction;
    logic [2:0]    imm_sel;
    logic [TW-1:0] in_tag;
    logic          out_ready;

    logic          in_ready32, out_valid32, err32;
    logic [31:0]   imm32;
    logic [TW-1:0] tag32;
    logic [15:0]   cnt32;
    logic          in_ready64, out_valid64, err64;
    logic [63:0]   imm64;
    logic [TW-1:0] tag64;
    logic [15:0]   cnt64;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .STAGES(S), .TAG_W(TW)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32),
        .instruction(instruction), .imm_sel(imm_sel), .in_tag(in_tag),
        .out_valid(out_valid32), .out_ready(out_ready), .immediate(imm32),
        .out_tag(tag32), .out_err(err32), .err_count(cnt32)
    );

    imm_gen_pipe #(.XLEN(64), .STAGES(S), .TAG_W(TW)) dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready64),
        .instruction(instruction), .imm_sel(imm_sel), .in_tag(in_tag),
        .out_valid(out_valid64), .out_ready(out_ready), .immediate(imm64),
        .out_tag(tag64), .out_err(err64), .err_count(cnt64)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Immediate value from the instruction-set definition, as plain integer arithmetic.
    function automatic logic [63:0] model_imm(input logic [31:0] inst, input logic [2:0] sel);
        longint x, u, v;
        int w;
        x = longint'(inst);
        u = 0;
        w = 64;
        case (sel)
            3'd0: begin u = (x >> 20) & 'hFFF; w = 12; end
            3'd1: begin u = ((x >> 25) & 'h7F) * 32 + ((x >> 7) & 'h1F); w = 12; end
            3'd2: begin
                u = ((x >> 31) & 1) * 4096 + ((x >> 7) & 1) * 2048
                  + ((x >> 25) & 'h3F) * 32 + ((x >> 8) & 'hF) * 2;
                w = 13;
            end
            3'd3: begin u = ((x >> 12) & 'hFFFFF) * 4096; w = 32; end
            3'd4: begin
                u = ((x >> 31) & 1) * (1 << 20) + ((x >> 12) & 'hFF) * 4096
                  + ((x >> 20) & 1) * 2048 + ((x >> 21) & 'h3FF) * 2;
                w = 21;
            end
            3'd5: begin u = (x >> 15) & 'h1F; w = 64; end
            default: begin u = 0; w = 64; end
        endcase
        if (w < 64 && u >= (longint'(1) << (w - 1))) v = u - (longint'(1) << w);
        else v = u;
        return v;
    endfunction

    // Model: FIFO of in-flight items with their age in edges since acceptance.
    logic [63:0]   q_imm[$];
    logic [TW-1:0] q_tag[$];
    logic          q_err[$];
    int            q_age[$];
    logic [15:0]   m_cnt = 16'd0;

    always @(negedge clk) begin
        logic exp_rdy, exp_vld;
        if (rst) begin
            q_imm.delete(); q_tag.delete(); q_err.delete(); q_age.delete();
            m_cnt = 16'd0;
        end else begin
            exp_rdy = (q_age.size() < S) || out_ready;
            exp_vld = (q_age.size() > 0) && (q_age[0] >= S - 1);
            chk("in_ready32", in_ready32, exp_rdy);
            chk("in_ready64", in_ready64, exp_rdy);
            chk("out_valid32", out_valid32, exp_vld);
            chk("out_valid64", out_valid64, exp_vld);
            if (exp_vld) begin
                chk("imm32", imm32, {32'b0, q_imm[0][31:0]});
                chk("imm64", imm64, q_imm[0]);
                chk("tag32", tag32, q_tag[0]);
                chk("tag64", tag64, q_tag[0]);
                chk("err32", err32, q_err[0]);
                chk("err64", err64, q_err[0]);
            end
            chk("err_count32", cnt32, m_cnt);
            chk("err_count64", cnt64, m_cnt);
            // Advance the model to the state after the coming rising edge.
            if (exp_vld && out_ready) begin
                void'(q_imm.pop_front()); void'(q_tag.pop_front());
                void'(q_err.pop_front()); void'(q_age.pop_front());
            end
            foreach (q_age[i]) q_age[i] = q_age[i] + 1;
            if (in_valid && exp_rdy) begin
                q_imm.push_back(model_imm(instruction, imm_sel));
                q_tag.push_back(in_tag);
                q_err.push_back(imm_sel >= 3'd6);
                q_age.push_back(0);
                if (imm_sel >= 3'd6 && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            end
        end
    end

    task automatic drive(input logic v, input logic [31:0] ins, input logic [2:0] sel,
                         input logic [TW-1:0] tag);
        @(posedge clk);
        #1;
        in_valid    = v;
        instruction = ins;
        imm_sel     = sel;
        in_tag      = tag;
    endtask

    logic [31:0] t1_ins [8] = '{32'hFFF00093, 32'h00112023, 32'h80000063, 32'h12345037,
                                32'h800000EF, 32'h000F8073, 32'h80000037, 32'h7FF00093};
    logic [2:0]  t1_sel [8] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b011, 3'b000};
    logic [31:0] t1_l32 [8] = '{32'hFFFFFFFF, 32'h00000000, 32'hFFFFF000, 32'h12345000,
                                32'hFFF00000, 32'h0000001F, 32'h80000000, 32'h000007FF};
    logic [63:0] t1_l64 [8] = '{64'hFFFFFFFFFFFFFFFF, 64'h0, 64'hFFFFFFFFFFFFF000,
                                64'h0000000012345000, 64'hFFFFFFFFFFF00000, 64'h000000000000001F,
                                64'hFFFFFFFF80000000, 64'h00000000000007FF};

    initial begin
        #1_500_000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        in_valid = 1'b0; instruction = '0; imm_sel = '0; in_tag = '0; out_ready = 1'b1;
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("rst_out_valid", out_valid32, 0);
        chk("rst_imm", imm32, 0);
        chk("rst_tag", tag32, 0);
        chk("rst_err", err32, 0);
        chk("rst_cnt", cnt32, 0);
        chk("rst_in_ready", in_ready32, 1);
        chk("rst_imm64", imm64, 0);
        @(posedge clk);
        @(posedge clk); #3 rst = 1'b0;

        // Back-to-back formats, output two cycles after acceptance.
        for (int k = 0; k < 10; k++) begin
            if (k < 8) drive(1'b1, t1_ins[k], t1_sel[k], TW'(k + 3));
            else drive(1'b0, 32'h0, 3'b000, '0);
            @(negedge clk);
            if (k >= 2) begin
                chk("t1_valid", out_valid32, 1);
                chk("t1_imm32", imm32, {32'b0, t1_l32[k-2]});
                chk("t1_imm64", imm64, t1_l64[k-2]);
                chk("t1_tag", tag32, TW'(k + 1));
            end
        end

        // Backpressure: two items fill the pipe, the third waits.
        drive(1'b1, 32'h00500093, 3'b000, 5'd20);
        out_ready = 1'b0;
        drive(1'b1, 32'hFE112E23, 3'b001, 5'd21);
        drive(1'b1, 32'hABCDE037, 3'b011, 5'd22);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready32, 0);
            chk("bp_hold_imm", imm32, 32'h00000005);
            chk("bp_hold_tag", tag32, 5'd20);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        chk("bp_item1", imm32, 32'h00000005);
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        chk("bp_item2", imm32, 32'hFFFFFFFC);
        chk("bp_item2_tag", tag32, 5'd21);
        @(negedge clk);
        chk("bp_item3", imm64, 64'hFFFFFFFFABCDE000);
        chk("bp_item3_tag", tag32, 5'd22);

        // Illegal selectors.
        drive(1'b1, 32'hFFFFFFFF, 3'b110, 5'd7);
        drive(1'b1, 32'h12345678, 3'b111, 5'd8);
        drive(1'b0, 32'h0, 3'b000, '0);
        @(negedge clk);
        chk("ill_err1", err32, 1);
        chk("ill_imm1", imm32, 0);
        chk("ill_tag1", tag32, 5'd7);
        chk("ill_cnt", cnt32, 16'd2);
        @(negedge clk);
        chk("ill_err2", err64, 1);
        chk("ill_imm2", imm64, 0);
        drive(1'b0, 32'h0, 3'b000, '0);
        out_ready = 1'b0;
        drive(1'b1, 32'h00100093, 3'b000, 5'd9);
        drive(1'b1, 32'h00200093, 3'b000, 5'd10);
        drive(1'b1, 32'hFFFFFFFF, 3'b111, 5'd11);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("ill_stall_rdy", in_ready32, 0);
            chk("ill_stall_cnt", cnt32, 16'd2);
        end
        @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("ill_after_drain_cnt", cnt32, 16'd2);

        // Saturation: bring the counter to FFFE, then three more illegal items.
        @(posedge clk); #1 in_valid = 1'b1; imm_sel = 3'b110; in_tag = '0;
        repeat (65531) @(posedge clk);
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        chk("sat_fffe", cnt32, 16'hFFFE);
        drive(1'b1, 32'h0, 3'b111, 5'd1);
        drive(1'b1, 32'h0, 3'b110, 5'd2);
        drive(1'b1, 32'h0, 3'b111, 5'd3);
        drive(1'b0, 32'h0, 3'b000, '0);
        @(negedge clk);
        chk("sat_ffff", cnt32, 16'hFFFF);
        repeat (3) @(negedge clk);
        chk("sat_hold", cnt64, 16'hFFFF);

        // Asynchronous reset with two items in flight.
        out_ready = 1'b0;
        drive(1'b1, 32'h00200093, 3'b000, 5'd4);
        drive(1'b1, 32'h00300093, 3'b110, 5'd5);
        drive(1'b0, 32'h0, 3'b000, '0);
        @(posedge clk); #3 rst = 1'b1;
        #1;
        chk("arst_out_valid", out_valid32, 0);
        chk("arst_out_valid64", out_valid64, 0);
        chk("arst_cnt", cnt32, 0);
        chk("arst_in_ready", in_ready32, 1);
        chk("arst_imm", imm32, 0);
        @(posedge clk); #3 rst = 1'b0; out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("arst_no_stale", out_valid32, 0);
        end
        drive(1'b1, 32'h00100093, 3'b000, 5'd9);
        drive(1'b0, 32'h0, 3'b000, '0);
        drive(1'b0, 32'h0, 3'b000, '0);
        @(negedge clk);
        chk("arst_new_valid", out_valid32, 1);
        chk("arst_new_imm", imm32, 32'h00000001);
        chk("arst_new_tag", tag32, 5'd9);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Parametrised, elastic, pipelined immediate generator for the decode stage.
- Extracts and sign-extends I/S/B/U/J immediates and the CSR zimm field to XLEN bits.
- Carries a tag through a STAGES-deep valid/ready pipeline.
- Flags illegal selector codes and counts them in a saturating error counter.
- Replaces the single-cycle combinational generator so decode can stall without losing operands.

Parameters:
XLEN, 32, immediate output width; legal values 32 or 64.
STAGES, 2, pipeline depth in register stages; legal range 1..4; elaboration-time error otherwise.
TAG_W, 5, width of the sideband tag (e.g. rd or ROB index) carried with each item.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  upstream holds a valid instruction.
in_ready  output  1  pipeline accepts this cycle.
instruction  input  32  raw RV32/RV64 instruction word.
imm_sel  input  3  000 I, 001 S, 010 B, 011 U, 100 J, 101 CSR zimm, 110/111 illegal.
in_tag  input  TAG_W  sideband tag.
out_valid  output  1  output item valid.
out_ready  input  1  downstream accepts.
immediate  output  XLEN  generated immediate.
out_tag  output  TAG_W  tag of the output item.
out_err  output  1  output item had an illegal imm_sel.
err_count  output  16  number of accepted illegal items; saturating.

Behaviour:
- Reset (async on rst high, no clock required):
  - all stage valid bits = 0, so out_valid = 0;
  - immediate, out_tag, out_err = 0;
  - err_count = 0;
  - in_ready = 1 one combinational step after reset, because all stages are empty.
- Extraction is combinational on the input side and registered into stage 1. Immediate encodings:
  - I: sext(inst[31:20]).
  - S: sext({inst[31:25], inst[11:7]}).
  - B: sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}).
  - U: sext({inst[31:12], 12'b0}). For XLEN=64, bits 63:32 replicate inst[31].
  - J: sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}).
  - CSR zimm: zero-extend(inst[19:15]).
  - Illegal (110/111): immediate = 0, err = 1.
- Sign extension is always to the full XLEN.
- Stage i is ready when !valid_i || ready_(i+1). The last stage's ready is out_ready. in_ready = ready of stage 1.
- A transfer occurs on in_valid && in_ready. Data advances stage to stage in the same cycle a slot frees, so throughput is 1 item/cycle with no bubbles.
- Latency: an item accepted at edge N appears with out_valid = 1 after edge N+STAGES-1, i.e. STAGES cycles from acceptance to consumption, assuming out_ready stays high.
- While out_valid && !out_ready, immediate, out_tag and out_err hold stable. An upstream stall does not drop or reorder items. Order is strictly FIFO.
- Full condition: all STAGES slots valid and out_ready = 0 forces in_ready = 0. Releasing out_ready drains one item per cycle.
- Simultaneous accept and drain when full: allowed. in_ready = 1 in the same cycle out_ready = 1, so there is no bubble.
- err_count increments by 1 on each input transfer with imm_sel in {110, 111}. It saturates at 16'hFFFF and never wraps. Illegal codes presented without a transfer (in_valid = 0, or in_ready = 0) do not count.
- Reset mid-operation clears all in-flight items immediately. No item emerges after reset deasserts unless it is newly accepted.
- Inputs are ignored when in_valid = 0; no X propagation into stage registers.

Test Plan:
1. XLEN=32, STAGES=2, out_ready=1. Feed back-to-back:
   - I 0xFFF00093 -> 0xFFFFFFFF
   - S 0x00112023 -> 0x00000000
   - B 0x80000063 -> 0xFFFFF000
   - U 0x12345037 -> 0x12345000
   - J 0x800000EF -> 0xFFF00000
   - sel 101 with 0x000F8073 -> 0x0000001F

   Each output appears 2 cycles after acceptance, one per cycle, with tags matching.
2. XLEN=64: U 0x80000037 -> 0xFFFFFFFF80000000; I 0x7FF00093 -> 0x00000000000007FF.
3. Backpressure, STAGES=2, out_ready=0, three items offered:
   - first two accepted, then in_ready=0;
   - output stays on item 1 stably for 5 cycles;
   - raise out_ready: items 1, 2, 3 emerge on consecutive cycles, in order.
4. Illegal selectors: sel 110 and 111 accepted -> immediate=0, out_err=1, err_count=2. A sel 111 held while in_ready=0 does not increment err_count.
5. Force err_count to 16'hFFFE, feed 3 illegal items -> err_count reads 16'hFFFF and stays there.
6. Assert rst mid-stream with 2 items in flight, asynchronously between edges:
   - out_valid drops at once and err_count=0;
   - after deassert, no stale item emerges;
   - the next accepted item I 0x00100093 -> 0x00000001.
